// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: fetch FSM encodings and
// default bus widths also used by the IR and the controller.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 2;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus: req/ack handshake with address and read data.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = instr_fetch_unit_pkg::DEF_ADDR_W,
  parameter int DATA_W = instr_fetch_unit_pkg::DEF_DATA_W
) ();

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_rd, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_rd, input mem_addr, output mem_ack, output mem_rdata);

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Prefetch FIFO holding {address, instruction} pairs; clear wins over push,
// and push+pop on the same edge is accepted even when full.
module fetch_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = instr_fetch_unit_pkg::DEF_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_W'(DEPTH));
  assign count     = r_count;
  assign rdata     = r_mem[r_rptr];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !clear) r_mem[r_wptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: prefetches from instruction memory into a small FIFO
// and hands the next instruction to the IR with a one-cycle LoadIR strobe.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_req,
  input  logic                jump_en,
  input  logic [ADDR_W-1:0]   jump_addr,
  instr_fetch_unit_if.master  mem,
  output logic [DATA_W-1:0]   instruction,
  output logic                LoadIR,
  output logic [ADDR_W-1:0]   pc,
  output logic                busy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e               r_state;
  fetch_state_e               w_state_nxt;
  logic [ADDR_W-1:0]          r_fetch_pc;
  logic [ADDR_W-1:0]          r_stale_addr;
  logic                       r_pending;
  logic                       r_load;
  logic [DATA_W-1:0]          r_instr;
  logic [ADDR_W-1:0]          r_pc;

  logic                       w_mem_rd;
  logic [ADDR_W-1:0]          w_mem_addr;
  logic                       w_ack;
  logic                       w_want;
  logic                       w_pop;
  logic                       w_push;
  logic                       w_empty;
  logic                       w_full;
  logic                       w_space;
  logic [CNT_W-1:0]           w_count;
  logic [CNT_W-1:0]           w_count_after;
  logic [ADDR_W+DATA_W-1:0]   w_head;

  // An ack is only meaningful while a read is actually being requested.
  assign w_ack  = mem.mem_ack & w_mem_rd;
  assign w_want = r_pending | fetch_req;
  assign w_pop  = w_want & ~w_empty & ~jump_en;
  assign w_push = w_ack & (r_state == ST_REQ) & ~jump_en;

  assign w_count_after = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_space       = (w_count_after < CNT_W'(DEPTH));

  fetch_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .clear (jump_en),
    .wdata ({r_fetch_pc, mem.mem_rdata}),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (jump_en || !w_full || w_pop) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (jump_en)    w_state_nxt = w_ack ? ST_REQ : ST_FLUSH;
        else if (w_ack) w_state_nxt = w_space ? ST_REQ : ST_IDLE;
      end
      ST_FLUSH: begin
        if (w_ack) w_state_nxt = ST_REQ;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FLUSH keeps presenting the abandoned address until memory completes it.
  always_comb begin
    w_mem_rd   = (r_state == ST_REQ) || (r_state == ST_FLUSH);
    w_mem_addr = (r_state == ST_FLUSH) ? r_stale_addr : r_fetch_pc;
  end

  assign mem.mem_rd   = w_mem_rd;
  assign mem.mem_addr = w_mem_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc   <= RESET_PC;
      r_stale_addr <= RESET_PC;
      r_pending    <= 1'b0;
      r_load       <= 1'b0;
      r_instr      <= '0;
      r_pc         <= RESET_PC;
    end else begin
      r_load    <= w_pop;
      r_pending <= w_want & ~w_pop & ~jump_en;
      if (w_pop) begin
        r_pc    <= w_head[ADDR_W+DATA_W-1:DATA_W];
        r_instr <= w_head[DATA_W-1:0];
      end
      if (jump_en) begin
        r_fetch_pc <= jump_addr;
        if (r_state == ST_REQ) r_stale_addr <= r_fetch_pc;
      end else if (w_push) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
      end
    end
  end

  assign instruction = r_instr;
  assign LoadIR      = r_load;
  assign pc          = r_pc;
  assign busy        = r_pending & w_empty;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: behavioural instruction memories with adjustable
// ack latency, and a scoreboard of {pc, instruction} expected at each LoadIR.
module tb_instr_fetch_unit;

  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // ---------------- DUT A: RESET_PC = 0 ----------------
  logic          reset_a = 1'b1;
  logic          fetch_req_a = 1'b0;
  logic          jump_en_a = 1'b0;
  logic [AW-1:0] jump_addr_a = '0;
  logic [DW-1:0] ins_a;
  logic          ld_a;
  logic [AW-1:0] pc_a;
  logic          busy_a;

  instr_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();

  instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(2), .RESET_PC(8'h00)) u_dut_a (
    .clk         (clk),
    .reset       (reset_a),
    .fetch_req   (fetch_req_a),
    .jump_en     (jump_en_a),
    .jump_addr   (jump_addr_a),
    .mem         (bus_a),
    .instruction (ins_a),
    .LoadIR      (ld_a),
    .pc          (pc_a),
    .busy        (busy_a)
  );

  logic [DW-1:0] mem_a [256];
  int            lat_a = 1;
  logic          stray_ack_a = 1'b0;
  logic [7:0]    wcnt_a = '0;

  always @(posedge clk) begin
    if (reset_a || !bus_a.mem_rd || bus_a.mem_ack) wcnt_a <= '0;
    else                                           wcnt_a <= wcnt_a + 8'd1;
  end
  assign bus_a.mem_ack   = (bus_a.mem_rd && int'(wcnt_a) >= lat_a) || stray_ack_a;
  assign bus_a.mem_rdata = mem_a[bus_a.mem_addr];

  // ---------------- DUT B: RESET_PC = 8'hFE ----------------
  logic          reset_b = 1'b1;
  logic          fetch_req_b = 1'b0;
  logic [DW-1:0] ins_b;
  logic          ld_b;
  logic [AW-1:0] pc_b;
  logic          busy_b;

  instr_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(2), .RESET_PC(8'hFE)) u_dut_b (
    .clk         (clk),
    .reset       (reset_b),
    .fetch_req   (fetch_req_b),
    .jump_en     (1'b0),
    .jump_addr   (8'h00),
    .mem         (bus_b),
    .instruction (ins_b),
    .LoadIR      (ld_b),
    .pc          (pc_b),
    .busy        (busy_b)
  );

  logic [7:0] wcnt_b = '0;
  always @(posedge clk) begin
    if (reset_b || !bus_b.mem_rd || bus_b.mem_ack) wcnt_b <= '0;
    else                                           wcnt_b <= wcnt_b + 8'd1;
  end
  assign bus_b.mem_ack   = bus_b.mem_rd && (wcnt_b >= 8'd1);
  assign bus_b.mem_rdata = bus_b.mem_addr ^ 8'h3C;

  // ---------------- scoreboard ----------------
  logic [15:0]   q_a [$];
  logic [15:0]   q_b [$];
  logic [AW-1:0] exp_pc_a = '0;
  logic [AW-1:0] exp_pc_b = 8'hFE;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_a && ld_a === 1'b1) begin
      if (q_a.size() == 0) begin
        chk("a_ld_spurious_qdepth", 32'(q_a.size()), 32'd1);
      end else begin
        logic [15:0] e;
        e = q_a.pop_front();
        chk("a_ld_pc", pc_a, e[15:8]);
        chk("a_ld_ins", ins_a, e[7:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_b && ld_b === 1'b1) begin
      if (q_b.size() == 0) begin
        chk("b_ld_spurious_qdepth", 32'(q_b.size()), 32'd1);
      end else begin
        logic [15:0] e;
        e = q_b.pop_front();
        chk("b_ld_pc", pc_b, e[15:8]);
        chk("b_ld_ins", ins_b, e[7:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_a(input bit expect_delivery);
    fetch_req_a = 1'b1;
    if (expect_delivery) begin
      q_a.push_back({exp_pc_a, mem_a[exp_pc_a]});
      exp_pc_a = exp_pc_a + 8'd1;
    end
    tick();
    fetch_req_a = 1'b0;
  endtask

  task automatic fetch_b();
    fetch_req_b = 1'b1;
    q_b.push_back({exp_pc_b, exp_pc_b ^ 8'h3C});
    exp_pc_b = exp_pc_b + 8'd1;
    tick();
    fetch_req_b = 1'b0;
  endtask

  task automatic reset_pulse_a(input int cycles);
    reset_a = 1'b1;
    repeat (cycles) tick();
    q_a.delete();
    exp_pc_a = '0;
    reset_a  = 1'b0;
  endtask

  task automatic check_reset_vals_a(input string pfx);
    chk({pfx, "_mem_rd"}, bus_a.mem_rd, 1'b0);
    chk({pfx, "_mem_addr"}, bus_a.mem_addr, 8'h00);
    chk({pfx, "_ins"}, ins_a, 8'h00);
    chk({pfx, "_ld"}, ld_a, 1'b0);
    chk({pfx, "_pc"}, pc_a, 8'h00);
    chk({pfx, "_busy"}, busy_a, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit got;
    int k;
    for (int i = 0; i < 256; i++) mem_a[i] = 8'(8'hA0 + i);

    // 1: reset values, prefetch fill, spaced fetches
    tick();
    tick();
    check_reset_vals_a("t1_rst");
    reset_a = 1'b0;
    q_a.delete();
    exp_pc_a = '0;
    chk("t1_rd_low_first", bus_a.mem_rd, 1'b0);
    tick();
    chk("t1_rd_rises", bus_a.mem_rd, 1'b1);
    repeat (8) tick();
    chk("t1_full_no_rd", bus_a.mem_rd, 1'b0);
    for (int i = 0; i < 3; i++) begin
      fetch_a(1'b1);
      chk("t1_ld_lat", ld_a, 1'b1);
      repeat (3) tick();
    end
    repeat (6) tick();
    chk("t1_refull_no_rd", bus_a.mem_rd, 1'b0);

    // 2: slow memory, fetch requested while FIFO empty
    lat_a = 5;
    reset_pulse_a(2);
    fetch_a(1'b1);
    chk("t2_first_rd", bus_a.mem_rd, 1'b1);
    got = 1'b0;
    k   = 0;
    while (!got && k < 20) begin
      @(negedge clk);
      if (bus_a.mem_rd && bus_a.mem_ack) got = 1'b1;
      else chk("t2_busy_wait", busy_a, 1'b1);
      k++;
    end
    chk("t2_ack_seen", got, 1'b1);
    tick();
    chk("t2_ld_not_yet", ld_a, 1'b0);
    chk("t2_busy_clear", busy_a, 1'b0);
    tick();
    chk("t2_ld", ld_a, 1'b1);
    chk("t2_ins", ins_a, 8'hA0);
    tick();
    chk("t2_ld_one_cycle", ld_a, 1'b0);

    // 3: zero-latency memory, fetch every cycle
    lat_a = 0;
    repeat (10) tick();
    chk("t3_full_no_rd", bus_a.mem_rd, 1'b0);
    for (int i = 0; i < 8; i++) begin
      fetch_a(1'b1);
      chk("t3_ld_every", ld_a, 1'b1);
    end
    repeat (4) tick();

    // 4: jump while read to address 2 is outstanding
    lat_a = 3;
    reset_pulse_a(2);
    repeat (14) tick();
    chk("t4_full_no_rd", bus_a.mem_rd, 1'b0);
    fetch_a(1'b1);
    chk("t4_ld", ld_a, 1'b1);
    chk("t4_rd_on", bus_a.mem_rd, 1'b1);
    chk("t4_rd_addr2", bus_a.mem_addr, 8'h02);
    jump_en_a   = 1'b1;
    jump_addr_a = 8'h40;
    fetch_req_a = 1'b1;
    exp_pc_a    = 8'h40;
    tick();
    jump_en_a   = 1'b0;
    fetch_req_a = 1'b0;
    chk("t4_no_ld_on_jump", ld_a, 1'b0);
    chk("t4_flush_rd", bus_a.mem_rd, 1'b1);
    chk("t4_flush_addr", bus_a.mem_addr, 8'h02);
    chk("t4_pending_dropped", busy_a, 1'b0);
    k = 0;
    while (bus_a.mem_addr == 8'h02 && k < 10) begin
      tick();
      k++;
    end
    chk("t4_redirect_addr", bus_a.mem_addr, 8'h40);
    chk("t4_redirect_rd", bus_a.mem_rd, 1'b1);
    fetch_a(1'b1);
    chk("t4_busy_after_jump", busy_a, 1'b1);
    repeat (20) tick();

    // 6: reset while a read is outstanding and a fetch is pending
    chk("t6_full_no_rd", bus_a.mem_rd, 1'b0);
    lat_a = 8;
    fetch_a(1'b1);
    chk("t6_ld_0", ld_a, 1'b1);
    fetch_a(1'b1);
    chk("t6_ld_1", ld_a, 1'b1);
    fetch_a(1'b0);
    chk("t6_busy", busy_a, 1'b1);
    chk("t6_rd_mid", bus_a.mem_rd, 1'b1);
    reset_a = 1'b1;
    tick();
    check_reset_vals_a("t6_rst");
    q_a.delete();
    exp_pc_a    = '0;
    reset_a     = 1'b0;
    stray_ack_a = 1'b1;
    tick();
    stray_ack_a = 1'b0;
    chk("t6_rd_after_rst", bus_a.mem_rd, 1'b1);
    chk("t6_addr_after_stray", bus_a.mem_addr, 8'h00);
    lat_a = 1;
    repeat (8) tick();
    fetch_a(1'b1);
    chk("t6_ld_after_rst", ld_a, 1'b1);
    repeat (3) tick();
    fetch_a(1'b1);
    repeat (3) tick();

    // 5: RESET_PC near the top of the address space wraps to 0
    reset_b = 1'b0;
    chk("t5_rst_addr", bus_b.mem_addr, 8'hFE);
    chk("t5_rst_pc", pc_b, 8'hFE);
    repeat (8) tick();
    for (int i = 0; i < 4; i++) begin
      fetch_b();
      chk("t5_ld", ld_b, 1'b1);
      repeat (2) tick();
    end
    repeat (5) tick();

    chk("a_queue_drained", 32'(q_a.size()), 32'd0);
    chk("b_queue_drained", 32'(q_b.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
